// File: rtl/bits_pack_if.sv
// Producer/consumer bus of the bit packer: field push side with backpressure,
// word pop side with consumer stall, plus the sticky protocol error flag.
interface bits_pack_if;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        stopout;
  logic        stopin;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  bitsout;
  logic        lastout;
  logic        errout;

  modport master (
    output pushin, lenin, datain, flushin, stopin,
    input  stopout, pushout, dataout, bitsout, lastout, errout
  );

  modport slave (
    input  pushin, lenin, datain, flushin, stopin,
    output stopout, pushout, dataout, bitsout, lastout, errout
  );
endinterface

// File: rtl/bits_pack.sv
// Bit packer: concatenates 0..15-bit fields MSB-first into 32-bit words,
// queues them in a small word FIFO and supports a zero-padding flush.
module bits_pack #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clock,
  input  logic        reset,
  bits_pack_if.slave  bus
);

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  bits;
    logic        last;
  } entry_t;

  localparam logic [AW:0] ALMOST_FULL = (AW+1)'(DEPTH - 1);

  // Valid bits are left-aligned in acc; bits below the valid region are always zero.
  logic [46:0]   acc, acc_nx, appended;
  logic [4:0]    cnt, cnt_nx;
  logic          flush_pend, flush_pend_nx;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;

  logic          push_ok, flush_go, enq, pop;
  entry_t        enq_entry;
  logic [14:0]   field_mask;
  logic [5:0]    shamt, sum;

  assign bus.stopout = (fcnt >= ALMOST_FULL);
  assign pop         = (fcnt != '0) && !bus.stopin;

  assign push_ok  = bus.pushin && !bus.stopout && (bus.lenin != 4'd0);
  assign flush_go = !bus.pushin && !bus.stopout && (flush_pend || bus.flushin);

  assign field_mask = 15'((16'h1 << bus.lenin) - 16'h1);
  assign sum        = {1'b0, cnt} + {2'b00, bus.lenin};
  // Field MSB must land just below the last valid accumulated bit.
  assign shamt      = 6'd47 - sum;
  assign appended   = acc | ({32'b0, bus.datain & field_mask} << shamt);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    acc_nx        = acc;
    cnt_nx        = cnt;
    enq           = 1'b0;
    enq_entry     = '0;
    flush_pend_nx = flush_pend;

    if (push_ok) begin
      if (sum >= 6'd32) begin
        enq       = 1'b1;
        enq_entry = '{word: appended[46:15], bits: 6'd32, last: 1'b0};
        acc_nx    = appended << 32;
        cnt_nx    = 5'(sum - 6'd32);
      end else begin
        acc_nx = appended;
        cnt_nx = sum[4:0];
      end
    end else if (flush_go && cnt != 5'd0) begin
      enq       = 1'b1;
      enq_entry = '{word: acc[46:15], bits: {1'b0, cnt}, last: 1'b1};
      acc_nx    = '0;
      cnt_nx    = '0;
    end

    // A flush arriving alongside a push waits until the producer goes idle.
    if (flush_go)
      flush_pend_nx = 1'b0;
    else if (bus.flushin && bus.pushin && !bus.stopout)
      flush_pend_nx = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fcnt        <= '0;
      bus.pushout <= 1'b0;
      bus.dataout <= '0;
      bus.bitsout <= '0;
      bus.lastout <= 1'b0;
      bus.errout  <= 1'b0;
    end else begin
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      flush_pend <= flush_pend_nx;
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fcnt        <= fcnt + (AW+1)'(enq) - (AW+1)'(pop);
      bus.pushout <= pop;
      if (pop)
        {bus.dataout, bus.bitsout, bus.lastout} <= mem[rd_ptr];
      if ((bus.pushin || bus.flushin) && bus.stopout)
        bus.errout <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (enq)
      mem[wr_ptr] <= enq_entry;
  end

endmodule

// File: tb/tb_bits_pack.sv
// Directed bench for bits_pack: packing, flush, deferred flush, backpressure,
// reset mid-operation and zero-length fields, with hand-computed words.
module tb_bits_pack;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  bits;
    logic        last;
  } obs_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  obs_t q[$];

  bits_pack_if bus ();

  bits_pack #(.DEPTH(4), .AW(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Records every emitted word, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.pushout === 1'b1)
      q.push_back('{word: bus.dataout, bits: bus.bitsout, last: bus.lastout});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_push(input logic [3:0] len, input logic [14:0] data);
    bus.pushin = 1'b1;
    bus.lenin  = len;
    bus.datain = data;
    @(posedge clock);
    #1;
    bus.pushin = 1'b0;
    bus.lenin  = 4'd0;
    bus.datain = 15'd0;
  endtask

  task automatic do_flush();
    bus.flushin = 1'b1;
    @(posedge clock);
    #1;
    bus.flushin = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++)
      @(posedge clock);
    #1;
  endtask

  // Counts negedges until pushout is seen; returns 0 if the budget expires.
  task automatic latency_to_pushout(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (bus.pushout === 1'b1) begin
        lat = i;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++; if (bus.pushout !== 1'b0) $display("FAIL reset_pushout: got %b expected 0", bus.pushout); else passes++;
    checks++; if (bus.dataout !== 32'h0) $display("FAIL reset_dataout: got %h expected 00000000", bus.dataout); else passes++;
    checks++; if (bus.bitsout !== 6'd0) $display("FAIL reset_bitsout: got %0d expected 0", bus.bitsout); else passes++;
    checks++; if (bus.lastout !== 1'b0) $display("FAIL reset_lastout: got %b expected 0", bus.lastout); else passes++;
    checks++; if (bus.errout !== 1'b0) $display("FAIL reset_errout: got %b expected 0", bus.errout); else passes++;
    checks++; if (bus.stopout !== 1'b0) $display("FAIL reset_stopout: got %b expected 0", bus.stopout); else passes++;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_full_word();
    int lat;
    q.delete();
    do_push(4'd15, 15'h7FFF);
    do_push(4'd15, 15'h0000);
    do_push(4'd2, 15'h0002);
    latency_to_pushout(10, lat);
    checks++; if (lat !== 2) $display("FAIL word_latency: got %0d expected 2", lat); else passes++;
    idle(3);
    checks++; if (q.size() !== 1) $display("FAIL word_count: got %0d expected 1", q.size()); else passes++;
    checks++; if (q[0].word !== 32'hFFFE0002) $display("FAIL word_data: got %h expected FFFE0002", q[0].word); else passes++;
    checks++; if (q[0].bits !== 6'd32) $display("FAIL word_bits: got %0d expected 32", q[0].bits); else passes++;
    checks++; if (q[0].last !== 1'b0) $display("FAIL word_last: got %b expected 0", q[0].last); else passes++;
  endtask

  task automatic test_flush();
    q.delete();
    do_push(4'd15, 15'h7FFF);
    do_push(4'd15, 15'h0000);
    do_push(4'd15, 15'h5555);
    do_flush();
    wait_words(2, 20);
    idle(3);
    checks++; if (q.size() !== 2) $display("FAIL flush_count: got %0d expected 2", q.size()); else passes++;
    checks++; if (q[0].word !== 32'hFFFE0002) $display("FAIL flush_w0_data: got %h expected FFFE0002", q[0].word); else passes++;
    checks++; if (q[0].bits !== 6'd32) $display("FAIL flush_w0_bits: got %0d expected 32", q[0].bits); else passes++;
    checks++; if (q[1].word !== 32'hAAA80000) $display("FAIL flush_w1_data: got %h expected AAA80000", q[1].word); else passes++;
    checks++; if (q[1].bits !== 6'd13) $display("FAIL flush_w1_bits: got %0d expected 13", q[1].bits); else passes++;
    checks++; if (q[1].last !== 1'b1) $display("FAIL flush_w1_last: got %b expected 1", q[1].last); else passes++;
  endtask

  task automatic test_deferred_flush();
    int lat;
    q.delete();
    bus.flushin = 1'b1;
    do_push(4'd4, 15'h000A);
    bus.flushin = 1'b0;
    latency_to_pushout(10, lat);
    checks++; if (lat !== 3) $display("FAIL defer_latency: got %0d expected 3", lat); else passes++;
    idle(2);
    checks++; if (q.size() !== 1) $display("FAIL defer_count: got %0d expected 1", q.size()); else passes++;
    checks++; if (q[0].word !== 32'hA0000000) $display("FAIL defer_data: got %h expected A0000000", q[0].word); else passes++;
    checks++; if (q[0].bits !== 6'd4) $display("FAIL defer_bits: got %0d expected 4", q[0].bits); else passes++;
    checks++; if (q[0].last !== 1'b1) $display("FAIL defer_last: got %b expected 1", q[0].last); else passes++;
    do_flush();
    idle(4);
    checks++; if (q.size() !== 1) $display("FAIL empty_flush: got %0d words expected 1", q.size()); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] words [3];
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC;
    q.delete();
    bus.stopin = 1'b1;
    for (int w = 0; w < 3; w++)
      for (int b = 3; b >= 0; b--) begin
        if (w == 2 && b == 0) begin
          checks++; if (bus.stopout !== 1'b0) $display("FAIL bp_stopout_low: got %b expected 0", bus.stopout); else passes++;
        end
        do_push(4'd8, {7'd0, words[w][b*8 +: 8]});
      end
    checks++; if (bus.stopout !== 1'b1) $display("FAIL bp_stopout_high: got %b expected 1", bus.stopout); else passes++;
    checks++; if (bus.errout !== 1'b0) $display("FAIL bp_err_before: got %b expected 0", bus.errout); else passes++;
    do_push(4'd8, 15'h00EE);
    checks++; if (bus.errout !== 1'b1) $display("FAIL bp_err_set: got %b expected 1", bus.errout); else passes++;
    checks++; if (q.size() !== 0) $display("FAIL bp_stalled: got %0d words expected 0", q.size()); else passes++;
    bus.stopin = 1'b0;
    @(posedge clock);
    for (int w = 0; w < 3; w++) begin
      @(negedge clock);
      checks++;
      if (bus.pushout !== 1'b1 || bus.dataout !== words[w])
        $display("FAIL bp_drain%0d: got pushout=%b data=%h expected pushout=1 data=%h", w, bus.pushout, bus.dataout, words[w]);
      else
        passes++;
    end
    @(negedge clock);
    checks++; if (bus.pushout !== 1'b0) $display("FAIL bp_drain_end: got %b expected 0", bus.pushout); else passes++;
    idle(1);
    do_flush();
    idle(4);
    checks++; if (q.size() !== 3) $display("FAIL bp_dropped_field: got %0d words expected 3", q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    q.delete();
    do_push(4'd7, 15'h0055);
    apply_reset();
    checks++; if (bus.errout !== 1'b0) $display("FAIL rst_err_clear: got %b expected 0", bus.errout); else passes++;
    do_push(4'd15, 15'h7FFF);
    do_push(4'd15, 15'h7FFF);
    do_push(4'd15, 15'h7FFF);
    do_flush();
    wait_words(2, 20);
    idle(3);
    checks++; if (q.size() !== 2) $display("FAIL rst_count: got %0d expected 2", q.size()); else passes++;
    checks++; if (q[0].word !== 32'hFFFFFFFF) $display("FAIL rst_w0_data: got %h expected FFFFFFFF", q[0].word); else passes++;
    checks++; if (q[1].word !== 32'hFFF80000) $display("FAIL rst_w1_data: got %h expected FFF80000", q[1].word); else passes++;
    checks++; if (q[1].bits !== 6'd13) $display("FAIL rst_w1_bits: got %0d expected 13", q[1].bits); else passes++;
    checks++; if (bus.errout !== 1'b0) $display("FAIL rst_errout: got %b expected 0", bus.errout); else passes++;
  endtask

  task automatic test_zero_len();
    q.delete();
    for (int i = 0; i < 5; i++)
      do_push(4'd0, 15'h7FFF);
    idle(4);
    checks++; if (q.size() !== 0) $display("FAIL zl_no_word: got %0d expected 0", q.size()); else passes++;
    checks++; if (bus.errout !== 1'b0) $display("FAIL zl_errout: got %b expected 0", bus.errout); else passes++;
    do_flush();
    idle(4);
    checks++; if (q.size() !== 0) $display("FAIL zl_flush_empty: got %0d expected 0", q.size()); else passes++;
  endtask

  initial begin
    reset       = 1'b1;
    bus.pushin  = 1'b0;
    bus.lenin   = 4'd0;
    bus.datain  = 15'd0;
    bus.flushin = 1'b0;
    bus.stopin  = 1'b0;
    test_reset();
    test_full_word();
    test_flush();
    test_deferred_flush();
    test_backpressure();
    test_reset_mid();
    test_zero_len();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
